// File: rtl/alu_logic_pipe.sv
// alu_logic_pipe: registered bitwise logic unit feeding a small result FIFO.
// Results carry zero/neg/err flags and a popped-result counter.
module alu_logic_pipe #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_err,
    output logic [CNT_W-1:0] ops_done
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic             err;
        logic [WIDTH-1:0] data;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          res;
    entry_t          head;
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic            push;
    logic            pop;

    assign in_ready  = (count != CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign head      = mem[rd_ptr];

    // Decode the operation into a result and error flag
    always_comb begin
        res = '0;
        unique case (op)
            3'b000: res.data = a & b;
            3'b001: res.data = a | b;
            3'b010: res.data = a ^ b;
            3'b011: res.data = ~(a | b);
            3'b100: res.data = a;
            3'b101: res.data = b;
            3'b110: res.data = ~a;
            3'b111: res.err  = 1'b1;
        endcase
    end

    // Result storage; contents are don't-care until marked valid by count
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= res;
        end
    end

    // Pointers, occupancy and completed-op counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ops_done <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr   <= rd_ptr + PW'(1);
                ops_done <= ops_done + CNT_W'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    // Present the head entry, forced to zero when the buffer is empty
    always_comb begin
        out_data = '0;
        out_zero = 1'b0;
        out_neg  = 1'b0;
        out_err  = 1'b0;
        if (out_valid) begin
            out_data = head.data;
            out_zero = (head.data == '0);
            out_neg  = head.data[WIDTH-1];
            out_err  = head.err;
        end
    end

endmodule

// File: tb/tb_alu_logic_pipe.sv
// tb_alu_logic_pipe: directed vectors for alu_logic_pipe.
// Inputs driven and outputs sampled on the falling edge.
module tb_alu_logic_pipe;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_zero;
    logic        out_neg;
    logic        out_err;
    logic [3:0]  ops_done;

    int n_cmp;
    int n_bad;
    logic [3:0] exp_ops;

    logic [31:0] tv_exp [8];
    logic        tv_neg [8];

    alu_logic_pipe #(
        .WIDTH(32),
        .DEPTH(2),
        .CNT_W(4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_zero (out_zero),
        .out_neg  (out_neg),
        .out_err  (out_err),
        .ops_done (ops_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic drive(input logic [2:0] o, input logic [31:0] x,
                         input logic [31:0] y);
        in_valid = 1'b1;
        op = o;
        a = x;
        b = y;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        exp_ops = '0;
        reset = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        op = '0;
        a = '0;
        b = '0;

        tv_exp[0] = 32'h000F000F; tv_neg[0] = 1'b0;
        tv_exp[1] = 32'h0FFF0FFF; tv_neg[1] = 1'b0;
        tv_exp[2] = 32'h0FF00FF0; tv_neg[2] = 1'b0;
        tv_exp[3] = 32'hF000F000; tv_neg[3] = 1'b1;
        tv_exp[4] = 32'h00FF00FF; tv_neg[4] = 1'b0;
        tv_exp[5] = 32'h0F0F0F0F; tv_neg[5] = 1'b0;
        tv_exp[6] = 32'hFF00FF00; tv_neg[6] = 1'b1;
        tv_exp[7] = 32'h00000000; tv_neg[7] = 1'b0;

        // reset state
        nxt();
        nxt();
        check("rst_ovalid", out_valid, 0);
        check("rst_iready", in_ready, 1);
        check("rst_data", out_data, 0);
        check("rst_ops", ops_done, 0);
        reset = 1'b1;

        // xor example, popped right away
        drive(3'b010, 32'hFFFF0000, 32'h0F0F0F0F);
        out_ready = 1'b1;
        nxt();
        in_valid = 1'b0;
        check("xor_valid", out_valid, 1);
        check("xor_data", out_data, 32'hF0F00F0F);
        check("xor_neg", out_neg, 1);
        check("xor_zero", out_zero, 0);
        check("xor_err", out_err, 0);
        check("xor_ops0", ops_done, 0);
        nxt();
        exp_ops++;
        check("xor_ops1", ops_done, exp_ops);
        check("xor_empty", out_valid, 0);
        check("empty_data", out_data, 0);

        // and-to-zero then reserved op, FIFO order
        out_ready = 1'b0;
        drive(3'b000, 32'hAAAAAAAA, 32'h55555555);
        nxt();
        drive(3'b111, 32'h12345678, 32'h9ABCDEF0);
        nxt();
        in_valid = 1'b0;
        check("full_iready", in_ready, 0);
        check("and_data", out_data, 0);
        check("and_zero", out_zero, 1);
        check("and_err", out_err, 0);
        out_ready = 1'b1;
        nxt();
        exp_ops++;
        check("rsv_valid", out_valid, 1);
        check("rsv_data", out_data, 0);
        check("rsv_zero", out_zero, 1);
        check("rsv_err", out_err, 1);
        nxt();
        exp_ops++;
        check("rsv_drained", out_valid, 0);
        check("rsv_ops", ops_done, exp_ops);

        // every opcode
        for (int i = 0; i < 8; i++) begin
            out_ready = 1'b0;
            drive(3'(i), 32'h00FF00FF, 32'h0F0F0F0F);
            nxt();
            in_valid = 1'b0;
            out_ready = 1'b1;
            check($sformatf("op%0d_data", i), out_data, tv_exp[i]);
            check($sformatf("op%0d_neg", i), out_neg, tv_neg[i]);
            check($sformatf("op%0d_err", i), out_err, (i == 7));
            nxt();
            exp_ops++;
        end
        check("ops_after_tbl", ops_done, exp_ops);

        // backpressure with DEPTH=2
        out_ready = 1'b0;
        drive(3'b100, 32'd1, 32'd0);
        check("bp_rdy1", in_ready, 1);
        nxt();
        drive(3'b100, 32'd2, 32'd0);
        check("bp_rdy2", in_ready, 1);
        nxt();
        drive(3'b100, 32'd3, 32'd0);
        check("bp_rdy3", in_ready, 0);
        nxt();
        check("bp_hold_rdy", in_ready, 0);
        check("bp_head1", out_data, 1);
        out_ready = 1'b1;
        nxt();
        exp_ops++;
        check("bp_head2", out_data, 2);
        check("bp_rdy_again", in_ready, 1);
        nxt();
        exp_ops++;
        in_valid = 1'b0;
        check("bp_head3", out_data, 3);
        nxt();
        exp_ops++;
        check("bp_empty", out_valid, 0);
        check("bp_ops", ops_done, exp_ops);

        // steady stream at occupancy 1
        out_ready = 1'b0;
        drive(3'b101, 32'd0, 32'd100);
        nxt();
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive(3'b101, 32'd0, 32'(101 + i));
            check($sformatf("st%0d_data", i), out_data, 32'(100 + i));
            check($sformatf("st%0d_rdy", i), in_ready, 1);
            nxt();
            exp_ops++;
        end
        in_valid = 1'b0;
        check("st_valid", out_valid, 1);
        check("st_last", out_data, 120);
        check("st_ops", ops_done, exp_ops);
        nxt();
        exp_ops++;
        check("st_drained", out_valid, 0);

        // reset pulse with a full buffer
        out_ready = 1'b0;
        drive(3'b110, 32'd0, 32'd0);
        nxt();
        nxt();
        in_valid = 1'b0;
        check("pre_rst_full", in_ready, 0);
        check("pre_rst_data", out_data, 32'hFFFFFFFF);
        #2;
        reset = 1'b0;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_rdy", in_ready, 1);
        check("arst_data", out_data, 0);
        check("arst_ops", ops_done, 0);
        #1;
        reset = 1'b1;
        exp_ops = '0;
        nxt();
        check("post_rst_v0", out_valid, 0);
        nxt();
        check("post_rst_v1", out_valid, 0);
        drive(3'b011, 32'h0000FFFF, 32'hFF000000);
        nxt();
        in_valid = 1'b0;
        check("nor_data", out_data, 32'h00FF0000);
        check("nor_zero", out_zero, 0);
        out_ready = 1'b1;
        nxt();
        exp_ops++;
        check("nor_ops", ops_done, exp_ops);

        // counter wrap: 16 more pops bring a 4-bit count back to 1
        for (int i = 0; i < 16; i++) begin
            out_ready = 1'b0;
            drive(3'b100, 32'(i + 7), 32'd0);
            nxt();
            in_valid = 1'b0;
            out_ready = 1'b1;
            nxt();
        end
        check("wrap_ops", ops_done, 1);
        out_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_logic_pipe.md
ALU_LOGIC_PIPE -- requirements
Module: alu_logic_pipe

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits, legal range 4..64.
REQ-002 Parameter DEPTH, default 2: result buffer entries, power of two, legal range 2..16.
REQ-003 Parameter CNT_W, default 16: width of the completed-operation counter.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset; 0 resets all state immediately.
REQ-006 in_valid  input  1  operand set and op are presented.
REQ-007 in_ready  output  1  block can accept an operand set this cycle.
REQ-008 op  input  3  operation select, per REQ-014.
REQ-009 a, b  input  WIDTH each  operands.
REQ-010 out_valid  output  1  buffer head holds a result.
REQ-011 out_ready  input  1  consumer takes the head result this cycle.
REQ-012 out_data  output  WIDTH; out_zero, out_neg, out_err  output  1 each  head result and its flags.
REQ-013 ops_done  output  CNT_W  count of results popped since reset.

Function
REQ-014 Op encoding: 000 a&b; 001 a|b; 010 a^b; 011 ~(a|b); 100 a; 101 b; 110 ~a; 111 reserved, result 0 and err=1.
REQ-015 out_zero is 1 iff the stored result is all zeros; out_neg equals the stored result's bit WIDTH-1; out_err is 1 only for op 111.
REQ-016 Accept occurs when in_valid=1 and in_ready=1 at a rising edge; the result and its flags are computed from that cycle's op/a/b and written to the buffer tail.
REQ-017 Latency: an accepted result into an empty buffer appears with out_valid=1 in the cycle immediately after the accepting edge; there is no combinational path from inputs to outputs.
REQ-018 Pop occurs when out_valid=1 and out_ready=1 at a rising edge; the head advances and ops_done increments by 1.
REQ-019 Results leave in acceptance order (FIFO); each accepted result is popped exactly once.
REQ-020 in_ready is 1 iff the buffer holds fewer than DEPTH entries; it does not depend on out_ready in the same cycle.
REQ-021 out_valid is 1 iff the buffer holds at least one entry.
REQ-022 When out_valid=0, out_data, out_zero, out_neg, out_err are all 0.
REQ-023 Simultaneous accept and pop with 1..DEPTH-1 entries: occupancy unchanged, both operations take effect.
REQ-024 Accept with one empty slot sets occupancy to DEPTH and drops in_ready the next cycle.
REQ-025 in_valid while in_ready=0: no state change; the source holds its data.
REQ-026 out_ready while out_valid=0: no state change; ops_done unchanged.
REQ-027 Read/write pointers wrap modulo DEPTH; occupancy is tracked with a counter 0..DEPTH.
REQ-028 ops_done wraps from 2^CNT_W-1 to 0.
REQ-029 op, a and b are ignored when in_valid=0.

Reset
REQ-030 reset=0 clears occupancy, both pointers and ops_done to 0 without waiting for clk.
REQ-031 During and after reset: out_valid=0, in_ready=1, out_data and flags 0, ops_done=0.
REQ-032 Reset asserted mid-stream discards all buffered results; no partial result is popped after release.
REQ-033 The first accept is possible on the first rising edge after reset returns to 1.

Verification
REQ-034 WIDTH=32: accept op=010, a=0xFFFF0000, b=0x0F0F0F0F, out_ready=1 -> next cycle out_valid=1, out_data=0xF0F00F0F, out_neg=1, out_zero=0, out_err=0; next edge ops_done=1.
REQ-035 Accept op=000, a=0xAAAAAAAA, b=0x55555555, then op=111 -> results 0x00000000 with out_zero=1, then 0 with out_err=1, popped in that order.
REQ-036 DEPTH=2, out_ready=0, three back-to-back in_valid -> in_ready falls after second accept, third held until a pop; buffer never exceeds 2; pops yield inputs 1,2,3 in order.
REQ-037 Buffer holding 1 entry, in_valid=1 and out_ready=1 every cycle for 20 cycles -> occupancy stays 1, out_valid stays 1, ops_done advances 20.
REQ-038 Buffer full, reset pulsed low between edges -> out_valid=0 and in_ready=1 immediately; after release, out_valid stays 0 until a new accept.
REQ-039 CNT_W=4, 17 pops -> ops_done reads 1.
